// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the program counter with return stack.
//   pc_op_t        - the single operation executed in a given cycle
//   PC_WIDTH_DEF   - default address width
//   PC_DEPTH_DEF   - default return-stack depth
package pc_pkg;

  localparam int PC_WIDTH_DEF = 12;
  localparam int PC_DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    OP_HOLD  = 3'd0,
    OP_COUNT = 3'd1,
    OP_LOAD  = 3'd2,
    OP_CALL  = 3'd3,
    OP_RET   = 3'd4
  } pc_op_t;

endpackage

// File: rtl/pc_stack_return_stack.sv
// return_stack: DEPTH x WIDTH register-file LIFO holding return addresses.
// Ports:
//   clk    - system clock
//   reset  - synchronous active-high reset (clears level only)
//   push   - write wdata at the current level (ignored when full)
//   pop    - drop the top entry (ignored when empty)
//   wdata  - return address to push
//   rdata  - current top entry (meaningless while empty)
//   level  - number of valid entries, 0..DEPTH
//   full   - level == DEPTH
//   empty  - level == 0
module return_stack
  import pc_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH_DEF,
  parameter int DEPTH = PC_DEPTH_DEF,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [LVL_W-1:0] level_r;
  logic [IDX_W-1:0] wr_idx_s;
  logic [IDX_W-1:0] rd_idx_s;
  logic             full_s;
  logic             empty_s;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_s    = (level_r == LVL_W'(DEPTH));
  assign empty_s   = (level_r == {LVL_W{1'b0}});
  // Illegal push/pop are swallowed here; the top turns them into sticky flags.
  assign do_push_s = push & ~full_s;
  assign do_pop_s  = pop & ~empty_s & ~push;

  // Index truncation is safe: a write only happens below DEPTH, a read only above 0.
  assign wr_idx_s = IDX_W'(level_r);
  assign rd_idx_s = IDX_W'(level_r - LVL_W'(1));

  // Occupancy counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_r <= {LVL_W{1'b0}};
    end else if (do_push_s) begin
      level_r <= level_r + LVL_W'(1);
    end else if (do_pop_s) begin
      level_r <= level_r - LVL_W'(1);
    end else begin
      level_r <= level_r;
    end
  end

  // Storage array: not cleared by reset, contents are unobservable at level 0.
  always_ff @(posedge clk) begin
    if (do_push_s && !reset) begin
      mem_r[wr_idx_s] <= wdata;
    end
  end

  assign rdata = mem_r[rd_idx_s];
  assign level = level_r;
  assign full  = full_s;
  assign empty = empty_s;

endmodule

// File: rtl/pc_stack.sv
// pc_stack: program counter with an integrated hardware return stack.
// Ports:
//   clk         - system clock
//   reset       - synchronous active-high reset, highest priority
//   in          - jump/call target address
//   nLoadEnable - active-low jump (out <= in)
//   countEnable - increment (out <= out + 1)
//   call        - push out+1, jump to in
//   ret         - jump to top of stack, pop
//   out         - registered program counter
//   level       - registered number of stacked return addresses
//   full/empty  - decoded from level
//   overflow    - sticky: call while full
//   underflow   - sticky: ret while empty
// Priority: call > ret > load > count > hold; losing requests are dropped.
module pc_stack
  import pc_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH_DEF,
  parameter int DEPTH = PC_DEPTH_DEF,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             nLoadEnable,
  input  logic             countEnable,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] out,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  pc_op_t           op_s;
  logic [WIDTH-1:0] out_r;
  logic [WIDTH-1:0] inc_s;
  logic [WIDTH-1:0] top_s;
  logic             push_s;
  logic             pop_s;
  logic             full_s;
  logic             empty_s;
  logic             overflow_r;
  logic             underflow_r;

  // Fixed-priority decode of the request lines into one operation.
  always_comb begin
    op_s = OP_HOLD;
    if (call) begin
      op_s = OP_CALL;
    end else if (ret) begin
      op_s = OP_RET;
    end else if (!nLoadEnable) begin
      op_s = OP_LOAD;
    end else if (countEnable) begin
      op_s = OP_COUNT;
    end else begin
      op_s = OP_HOLD;
    end
  end

  // Wraps modulo 2^WIDTH; also used as the pushed return address.
  assign inc_s  = out_r + WIDTH'(1);
  assign push_s = (op_s == OP_CALL);
  assign pop_s  = (op_s == OP_RET);

  return_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_return_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (inc_s),
    .rdata (top_s),
    .level (level),
    .full  (full_s),
    .empty (empty_s)
  );

  // Program counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_r <= {WIDTH{1'b0}};
    end else begin
      case (op_s)
        OP_CALL:  out_r <= full_s  ? out_r : in;
        OP_RET:   out_r <= empty_s ? out_r : top_s;
        OP_LOAD:  out_r <= in;
        OP_COUNT: out_r <= inc_s;
        OP_HOLD:  out_r <= out_r;
        default:  out_r <= out_r;
      endcase
    end
  end

  // Sticky error flags; they never block later valid operations.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= overflow_r  | (push_s & full_s);
      underflow_r <= underflow_r | (pop_s & empty_s);
    end
  end

  assign out       = out_r;
  assign full      = full_s;
  assign empty     = empty_s;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;

endmodule

// File: tb/tb_pc_stack.sv
// Directed bench for pc_stack with hand-computed expectations (WIDTH=12, DEPTH=4).
module tb_pc_stack;

  logic        clk;
  logic        reset;
  logic [11:0] in;
  logic        nLoadEnable;
  logic        countEnable;
  logic        call;
  logic        ret;
  logic [11:0] out;
  logic [2:0]  level;
  logic        full;
  logic        empty;
  logic        overflow;
  logic        underflow;

  int checks   = 0;
  int failures = 0;

  pc_stack #(.WIDTH(12), .DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .in          (in),
    .nLoadEnable (nLoadEnable),
    .countEnable (countEnable),
    .call        (call),
    .ret         (ret),
    .out         (out),
    .level       (level),
    .full        (full),
    .empty       (empty),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle before sampling and driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    nLoadEnable = 1'b1; countEnable = 1'b0; call = 1'b0; ret = 1'b0;
  endtask

  task automatic st(input string tag, input logic [11:0] o, input logic [2:0] l,
                    input logic ov, input logic un);
    chk({tag, ".out"}, 32'(out), 32'(o));
    chk({tag, ".level"}, 32'(level), 32'(l));
    chk({tag, ".ovf"}, 32'(overflow), 32'(ov));
    chk({tag, ".unf"}, 32'(underflow), 32'(un));
  endtask

  initial begin
    reset = 1'b1; in = 12'h000; idle();
    step();
    st("reset", 12'h000, 3'd0, 1'b0, 1'b0);
    chk("reset.empty", 32'(empty), 32'd1);
    chk("reset.full", 32'(full), 32'd0);

    // Count from zero.
    reset = 1'b0; countEnable = 1'b1;
    step(); step(); step();
    st("count3", 12'h003, 3'd0, 1'b0, 1'b0);
    chk("count3.empty", 32'(empty), 32'd1);

    // Wrap with no flag.
    idle(); nLoadEnable = 1'b0; in = 12'hFFE;
    step();
    chk("load_ffe", 32'(out), 32'h0FFE);
    idle(); countEnable = 1'b1;
    step();
    chk("wrap_fff", 32'(out), 32'h0FFF);
    step();
    st("wrap_000", 12'h000, 3'd0, 1'b0, 1'b0);

    // Nested call/ret.
    idle(); nLoadEnable = 1'b0; in = 12'h010;
    step();
    idle(); call = 1'b1; in = 12'h100;
    step();
    st("call1", 12'h100, 3'd1, 1'b0, 1'b0);
    in = 12'h200;
    step();
    st("call2", 12'h200, 3'd2, 1'b0, 1'b0);
    idle(); ret = 1'b1;
    step();
    st("ret1", 12'h101, 3'd1, 1'b0, 1'b0);
    step();
    st("ret2", 12'h011, 3'd0, 1'b0, 1'b0);
    chk("ret2.empty", 32'(empty), 32'd1);

    // Fill the stack: pushes 0x012, 0x401, 0x501, 0x601.
    idle(); call = 1'b1;
    in = 12'h400; step();
    in = 12'h500; step();
    in = 12'h600; step();
    in = 12'h700; step();
    st("fill", 12'h700, 3'd4, 1'b0, 1'b0);
    chk("fill.full", 32'(full), 32'd1);
    in = 12'h3AB; step();
    st("ovf_call", 12'h700, 3'd4, 1'b1, 1'b0);
    chk("ovf_call.full", 32'(full), 32'd1);
    idle(); ret = 1'b1;
    step();
    st("ovf_ret", 12'h601, 3'd3, 1'b1, 1'b0);
    chk("ovf_ret.full", 32'(full), 32'd0);
    step(); chk("pop_501", 32'(out), 32'h0501);
    step(); chk("pop_401", 32'(out), 32'h0401);
    step(); st("pop_012", 12'h012, 3'd0, 1'b1, 1'b0);

    // Underflow: ret on empty holds out.
    step();
    st("unf_ret", 12'h012, 3'd0, 1'b1, 1'b1);

    // All requests together: only the call runs (pushes 0x013).
    call = 1'b1; ret = 1'b1; nLoadEnable = 1'b0; countEnable = 1'b1; in = 12'h0AA;
    step();
    st("prio", 12'h0AA, 3'd1, 1'b1, 1'b1);
    idle(); ret = 1'b1;
    step();
    st("prio_ret", 12'h013, 3'd0, 1'b1, 1'b1);

    // Pushed return address wraps at 0xFFF.
    idle(); nLoadEnable = 1'b0; in = 12'hFFF;
    step();
    idle(); call = 1'b1; in = 12'h050;
    step();
    chk("wcall.out", 32'(out), 32'h0050);
    idle(); ret = 1'b1;
    step();
    chk("wret.out", 32'(out), 32'h0000);
    chk("wret.level", 32'(level), 32'd0);

    // Reset coincident with a call at level 2.
    idle(); call = 1'b1;
    in = 12'h100; step();
    in = 12'h200; step();
    chk("pre_rst.level", 32'(level), 32'd2);
    reset = 1'b1; in = 12'h300;
    step();
    st("rst_mid", 12'h000, 3'd0, 1'b0, 1'b0);
    chk("rst_mid.empty", 32'(empty), 32'd1);
    reset = 1'b0; idle(); ret = 1'b1;
    step();
    st("rst_unf", 12'h000, 3'd0, 1'b0, 1'b1);

    idle();
    step();
    st("hold", 12'h000, 3'd0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_stack.md
# pc_stack

Parametrised program counter with an integrated hardware return stack. It is the next-generation replacement for the plain load/count program counter in the CPU fetch path. It adds call/return with a LIFO of return addresses, depth and status outputs, and sticky overflow/underflow error flags. All state updates are registered on one clock, with a synchronous active-high reset.

## Interface
- WIDTH, 12: address width in bits; must be ≥ 2.
- DEPTH, 4: return-stack entries; must be ≥ 1.
- LVL_W, $clog2(DEPTH+1): width of `level`; derived, not overridden.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset; sampled on the rising edge of clk.
- in  in  WIDTH  jump/call target address.
- nLoadEnable  in  1  active-low jump: out <= in.
- countEnable  in  1  active-high increment: out <= out + 1.
- call  in  1  push out+1, then out <= in.
- ret  in  1  out <= top of stack, then pop.
- out  out  WIDTH  current program counter; registered.
- level  out  LVL_W  number of valid stack entries (0..DEPTH); registered.
- full  out  1  level == DEPTH; combinational from level.
- empty  out  1  level == 0; combinational from level.
- overflow  out  1  sticky: a call was attempted while full.
- underflow  out  1  sticky: a ret was attempted while empty.

## Operation
- Reset (reset=1 at the edge) has priority over everything. It sets out=0, level=0, overflow=0, underflow=0. Stack RAM contents are not cleared; they are unobservable while level=0.
- Otherwise exactly one operation executes per cycle, chosen by fixed priority: call > ret > load (nLoadEnable=0) > count (countEnable=1) > hold. Lower-priority requests in the same cycle are dropped, not queued.
- CALL when not full: stack[level] <= out+1 (mod 2^WIDTH); level += 1; out <= in.
- CALL when full: out, level and stack are unchanged; overflow <= 1.
- RET when not empty: out <= stack[level-1]; level -= 1.
- RET when empty: out and level are unchanged; underflow <= 1.
- LOAD: out <= in. Stack is unchanged.
- COUNT: out <= out+1, wrapping from 2^WIDTH−1 to 0 with no flag.
- HOLD: no change.
- overflow and underflow stay set until reset. Setting them does not block later valid operations.
- Arithmetic is unsigned, modulo 2^WIDTH. A pushed return address also wraps (call at out=0xFFF pushes 0x000).

## Timing
- Single-cycle latency: an operation sampled at edge N is visible on out, level and the flags after edge N. There are no multi-cycle states.
- full and empty follow level combinationally in the same cycle.
- A call immediately followed by a ret returns to the call address + 1 after two edges.
- Back-to-back calls and rets are legal every cycle.
- Reset asserted in the middle of any sequence takes effect at that edge. Any in-progress call/ret in that cycle is discarded.
- Inputs must be stable around the clk rising edge. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `pc_pkg`:
  - op enum `pc_op_t` {OP_HOLD, OP_COUNT, OP_LOAD, OP_CALL, OP_RET};
  - default WIDTH/DEPTH localparams.
- Top-level work: priority decode into pc_op_t (combinational), the out register, and the flag registers.
- One sub-module, `return_stack`: DEPTH×WIDTH register-file LIFO.
  - Ports: clk, reset, push, pop, wdata, rdata (top), level, full, empty.
  - It owns level and guards against illegal push/pop.
  - pc_stack derives overflow and underflow from push&full and pop&empty.

## Test plan
Defaults WIDTH=12, DEPTH=4.
- Reset/count: reset=1 for one edge, then countEnable=1 for 3 edges -> out=0x000, then 0x003; level=0; empty=1.
- Wrap: load 0xFFE, count 2 edges -> out=0xFFF, then 0x000; no flag set.
- Nested call/ret: from out=0x010, call in=0x100, call in=0x200, then ret, ret -> out=0x100, 0x200, 0x101, 0x011; level=1, 2, 1, 0.
- Overflow: 4 calls -> full=1. A 5th call with in=0x3AB -> out unchanged, level=4, overflow=1. Then ret succeeds and overflow stays 1.
- Underflow and priority:
  - ret while empty -> underflow=1, out held.
  - call, ret, nLoadEnable=0 and countEnable=1 all asserted together -> only the call executes.
- Reset mid-operation: reset=1 coincident with a call at level=2 -> out=0, level=0, flags cleared. A following ret sets underflow=1.
